// File: rtl/ram_regfile_param.sv
// Parametrised single-port register-file RAM with byte-enabled writes,
// a registered read with a valid strobe, and a sequential clear engine.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   en         access request, taken only when idle and no clear_req
//   rw         1 = write, 0 = read
//   address    word address
//   be         per-byte write enables
//   data_in    write data
//   clear_req  one-cycle request to zero every entry
//   data_out   registered read data, held between reads
//   rd_valid   one-cycle pulse when data_out was updated by a read
//   busy       clear engine running, requests ignored
//   err        one-cycle pulse when an accepted access was out of range
module ram_regfile_param #(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 8,
    parameter int ADDR_W         = 3,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                rw,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                clear_req,
    output logic [DATA_W-1:0]   data_out,
    output logic                rd_valid,
    output logic                busy,
    output logic                err
);

    localparam int NB = DATA_W / 8;

    // One extra bit so DEPTH == 1<<ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        READY,
        CLEAR
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_n;
    logic              busy_n;

    logic [DATA_W-1:0] mem [DEPTH];

    logic accept;
    logic in_range;
    logic last;

    // A clear request wins over a same-cycle access, which is dropped.
    assign accept   = (state == READY) && !clear_req && en;
    assign in_range = {1'b0, address} < DEPTH_X;
    assign last     = (ptr == LAST);

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        busy_n  = busy;
        unique case (state)
            READY: begin
                if (clear_req) begin
                    state_n = CLEAR;
                    ptr_n   = '0;
                    busy_n  = 1'b1;
                end
            end
            CLEAR: begin
                ptr_n = ptr + 1'b1;
                if (last) begin
                    state_n = READY;
                    ptr_n   = '0;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = READY;
                ptr_n   = '0;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR_ON_RESET ? CLEAR : READY;
            ptr      <= '0;
            busy     <= CLEAR_ON_RESET;
            data_out <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            busy     <= busy_n;
            rd_valid <= accept && !rw;
            err      <= accept && !in_range;
            if (accept && !rw) begin
                data_out <= in_range ? mem[address] : '0;
            end
        end
    end

    // Storage has no reset so contents can survive it when not cleared.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[ptr] <= '0;
            end else if (accept && rw && in_range) begin
                for (int i = 0; i < NB; i++) begin
                    if (be[i]) begin
                        mem[address][8*i +: 8] <= data_in[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule
